// File: rtl/rsa_pkg.sv
// Definitions shared across the RSA datapath: FSM state encoding and loop-count sizing.
package rsa_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFin  = 2'd2
  } state_e;

  // R = 2^nbits, so R^2 needs 2*nbits modular doublings starting from 1.
  function automatic int unsigned calc_iter(input int unsigned nbits);
    return 2 * nbits;
  endfunction

endpackage

// File: rtl/mod_double_step.sv
// One modular doubling: r_next = 2*r mod m, valid whenever r < m.
module mod_double_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] r_next
);

  logic [WIDTH:0] t;

  always_comb begin
    t = {r, 1'b0};
    // With r < m, 2r < 2m, so a single subtraction always reduces fully.
    if (t >= {1'b0, m}) begin
      r_next = WIDTH'(t - {1'b0, m});
    end else begin
      r_next = WIDTH'(t);
    end
  end

endmodule

// File: rtl/const_precompute_unit.sv
// Computes the Montgomery constant R^2 mod M (R = 2^(WIDTH+2)) by repeated modular doubling,
// with a start/busy/done handshake and a sticky error for even or zero moduli.
module const_precompute_unit
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] M,
  output logic [WIDTH-1:0] Const,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned NBITS = WIDTH + 2;
  localparam int unsigned ITER  = calc_iter(NBITS);
  localparam int unsigned CntW  = $clog2(ITER + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] const_q, const_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] r_step;

  mod_double_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .r     (r_q),
    .m     (m_q),
    .r_next(r_step)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    const_d = const_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    if (en) begin
      done_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            m_d   = M;
            err_d = 1'b0;
            // Bit 0 clear covers both even M and M == 0.
            if (!M[0]) begin
              state_d = StFin;
            end else begin
              r_d     = {{(WIDTH-1){1'b0}}, 1'b1};
              cnt_d   = '0;
              busy_d  = 1'b1;
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          r_d   = r_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(ITER - 1)) begin
            busy_d  = 1'b0;
            state_d = StFin;
          end
        end
        StFin: begin
          done_d  = 1'b1;
          state_d = StIdle;
          if (!m_q[0]) begin
            err_d = 1'b1;
          end else if (m_q == WIDTH'(1)) begin
            // The loop never reduces the initial r=1 when m=1, so force the result.
            const_d = '0;
          end else begin
            const_d = r_q;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      r_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      const_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      const_q <= const_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Const = const_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_const_precompute_unit.sv
// Randomized self-checking bench for const_precompute_unit against a 2^20 mod M model.
module tb_const_precompute_unit;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic             start;
  logic [WIDTH-1:0] M;
  logic [WIDTH-1:0] Const;
  logic             busy;
  logic             done;
  logic             err;

  int n_checks = 0;
  int n_pass   = 0;
  int overlap  = 0;

  const_precompute_unit #(
    .WIDTH(WIDTH)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .start(start),
    .M    (M),
    .Const(Const),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy && done) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: R^2 mod M with R = 2^(WIDTH+2), using wide arithmetic directly.
  function automatic logic [31:0] ref_const(input int unsigned m);
    longint unsigned r2;
    if (m == 1) return 0;
    r2 = 64'd1 << (2 * (WIDTH + 2));
    return 32'(r2 % longint'(m));
  endfunction

  // Launches start with modulus m at the next edge (edge 0) and watches the edges that follow.
  // en is dropped for edges [stall_at, stall_at+stall_len); start re-pulses at edge glitch_at.
  task automatic run_op(input logic [7:0] m, input int stall_at, input int stall_len,
                        input int glitch_at, input int window, input bit early,
                        output int lat, output int busy_cyc, output int done_cnt);
    @(negedge clk);
    M     = m;
    start = 1'b1;
    lat      = -1;
    busy_cyc = 0;
    done_cnt = 0;
    for (int e = 0; e < window; e++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        if (lat < 0) lat = e;
      end
      if (early && lat >= 0) break;
      @(negedge clk);
      start = (glitch_at > 0) && (e + 1 == glitch_at);
      en    = !((stall_len > 0) && (e + 1 >= stall_at) && (e + 1 < stall_at + stall_len));
    end
    start = 1'b0;
    en    = 1'b1;
  endtask

  initial begin
    int lat, bc, dc;
    int m;
    rst   = 1'b1;
    en    = 1'b1;
    start = 1'b0;
    M     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_const", 32'(Const), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(8'd13, 0, 0, 0, 100, 1'b1, lat, bc, dc);
    check("m13_lat", 32'(lat), 21);
    check("m13_busy_cycles", 32'(bc), 20);
    check("m13_const", 32'(Const), ref_const(13));
    check("m13_const_lit", 32'(Const), 9);
    check("m13_err", 32'(err), 0);

    run_op(8'd255, 0, 0, 0, 100, 1'b1, lat, bc, dc);
    check("m255_lat", 32'(lat), 21);
    check("m255_const", 32'(Const), 16);
    run_op(8'd251, 0, 0, 0, 100, 1'b1, lat, bc, dc);
    check("m251_b2b_lat", 32'(lat), 21);
    check("m251_const", 32'(Const), ref_const(251));

    run_op(8'd12, 0, 0, 0, 100, 1'b1, lat, bc, dc);
    check("m12_lat", 32'(lat), 1);
    check("m12_err", 32'(err), 1);
    check("m12_const_kept", 32'(Const), 149);
    check("m12_no_busy", 32'(bc), 0);
    run_op(8'd0, 0, 0, 0, 100, 1'b1, lat, bc, dc);
    check("m0_lat", 32'(lat), 1);
    check("m0_err", 32'(err), 1);
    check("m0_const_kept", 32'(Const), 149);

    run_op(8'd1, 0, 0, 0, 100, 1'b1, lat, bc, dc);
    check("m1_lat", 32'(lat), 21);
    check("m1_const", 32'(Const), 0);
    check("m1_err_cleared", 32'(err), 0);

    run_op(8'd13, 5, 5, 0, 100, 1'b1, lat, bc, dc);
    check("stall_lat", 32'(lat), 26);
    check("stall_const", 32'(Const), 9);

    run_op(8'd13, 0, 0, 10, 50, 1'b0, lat, bc, dc);
    check("glitch_done_count", 32'(dc), 1);
    check("glitch_lat", 32'(lat), 21);
    check("glitch_const", 32'(Const), 9);

    // Abort mid-computation with reset.
    @(negedge clk);
    M     = 8'd13;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy_before_rst", 32'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_const", 32'(Const), 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'd13, 0, 0, 0, 100, 1'b1, lat, bc, dc);
    check("post_rst_lat", 32'(lat), 21);
    check("post_rst_const", 32'(Const), 9);

    for (int i = 0; i < 25; i++) begin
      m = 2 * $urandom_range(1, 127) + 1;
      run_op(8'(m), 0, 0, 0, 100, 1'b1, lat, bc, dc);
      check($sformatf("rand_m%0d_const", m), 32'(Const), ref_const(m));
      check($sformatf("rand_m%0d_lat", m), 32'(lat), 21);
    end

    check("busy_done_overlap", 32'(overlap), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/const_precompute_unit.md
Name: const_precompute_unit

Overview:
- Upstream stage of the RSA datapath that produces the Montgomery constant Const = R^2 mod M, where R = 2^(WIDTH+2).
- Const feeds the RSA unit's Const input, so software needs to supply only the modulus.
- Uses an iterative shift-and-conditional-subtract loop, one modular doubling per clock.
- A start/busy/done handshake lets the top-level controller launch the RSA unit only once Const is valid.

Parameters:
- WIDTH, 8, operand width in bits. NBITS = WIDTH+2 and ITER = 2*NBITS are derived localparams.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- en  input  1  clock enable; when low, all state and outputs hold
- start  input  1  request a new computation; sampled only in IDLE with en=1
- M  input  WIDTH  modulus; captured into an internal register on accepted start
- Const  output  WIDTH  R^2 mod M; held until the next successful completion
- busy  output  1  high while in CALC
- done  output  1  one-cycle pulse when Const is updated, or when an error is flagged
- err  output  1  sticky; set when the captured M is even or zero; cleared on the next accepted start

Behaviour:
- Reset (rst=1 at a clk edge, regardless of en): state=IDLE, Const=0, busy=0, done=0, err=0, r=0, cnt=0, m_reg=0.
- Reset applied mid-CALC aborts the computation; Const returns to 0.
- FSM states are IDLE, CALC, FIN. All transitions require en=1; en=0 freezes the current state, r, cnt and all outputs.
- IDLE: on start=1, capture m_reg<=M, clear err, and branch:
  - M even or M==0: go to FIN with an error flag set.
  - Otherwise: set r<=1, cnt<=0 and go to CALC. busy rises on the same edge.
- CALC, one iteration per enabled cycle:
  - t = {r,1'b0}, WIDTH+1 bits.
  - r <= (t >= m_reg) ? t - m_reg : t.
  - cnt <= cnt+1.
  - When cnt == ITER-1, go to FIN.
- Width rule: the invariant r < m_reg < 2^WIDTH holds throughout. t needs WIDTH+1 bits and the subtraction never underflows. cnt is $clog2(ITER+1) bits.
- Initial r=1 is not pre-reduced. For m_reg==1, the first iteration gives t=2, r=1 (2-1=1), which is wrong, so M==1 is special-cased: Const=0 with no error.
- FIN, for one cycle:
  - Normal path: Const <= r[WIDTH-1:0], or 0 when m_reg==1.
  - Error path: err<=1 and Const is unchanged.
  - In both cases done=1, busy=0, and the next state is IDLE.
- Latency, with en held high: start sampled at edge 0 gives busy high after edge 0, ITER CALC cycles, and done high for the cycle after edge ITER+1. Const is valid from that same edge. For WIDTH=8 this is done after edge 21.
- Error path latency: done after edge 1.
- start while busy or in FIN is ignored and is not queued.
- M changing during CALC has no effect, because m_reg was latched on accepted start.
- done and busy are never high together.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package rsa_pkg holds:
  - state encoding (IDLE=2'd0, CALC=2'd1, FIN=2'd2)
  - a function computing the ITER count from WIDTH, reusable by the RSA control FSM.
- One natural sub-module, mod_double_step (WIDTH): purely combinational r_next = 2r mod m, given r < m. It is reusable for other modular-reduction helpers.
- FSM, counter and registers stay in the top block.

Test Plan (WIDTH=8, ITER=20):
- M=13, start pulse -> busy for 20 cycles; done after edge 21; Const=9 (2^20 mod 13); err=0.
- M=255 -> Const=16. M=251 -> Const=149. Back-to-back starts issued on the cycle after done are both accepted.
- M=1 -> Const=0, err=0. M=12 (even) and M=0 -> done one cycle after start, err=1, Const keeps its previous value (149).
- With M=13, drop en for 5 cycles mid-CALC -> done delayed by exactly 5 cycles; Const=9. Pulse start during CALC -> ignored, with no second done.
- Assert rst at CALC cycle 10 -> next cycle busy=0, done=0, Const=0, state IDLE. A fresh start with M=13 then gives Const=9.
- Random odd M in 3..255 against a reference model of 2^20 mod M -> all match; busy/done never overlap.
